// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arb_pkg                                                    |
// | Purpose  : Shared definitions for the data-memory arbiter: owner-state     |
// |            encoding, starvation-limit default and counter width.           |
// | Ports    : none (package)                                                  |
// | Config   : DMEM_ARB_STARVE_GUARD_EN selects the starvation guard in the    |
// |            arbiter; this package is identical in both builds.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package dmem_arb_pkg;

  // Who drives the data-memory bus this cycle. OWN_CPU is the parking state.
  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Consecutive denied DMA cycles before the DMA is forced onto the bus.
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  // Enough bits to hold the largest legal STARVE_MAX (15).
  localparam int unsigned STARVE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arb_starve_cnt                                             |
// | Purpose  : Counts consecutive cycles in which a pending DMA request was    |
// |            refused in favour of the CPU, and flags when the DMA must win.  |
// | Ports    : clk, rst        clock / asynchronous active-high reset          |
// |            dma_wait   in   DMA requesting, CPU owns bus, no handover       |
// |            clear      in   DMA handed the bus, or DMA request withdrawn    |
// |            limit      out  this cycle is the STARVE_MAX-th refused cycle   |
// | Config   : instantiated by dmem_arbiter only under                         |
// |            DMEM_ARB_STARVE_GUARD_EN.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_wait,
  input  logic clear,
  output logic limit
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX   = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W:0]   CNT_MAX_X = (STARVE_CNT_W + 1)'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;
  logic [STARVE_CNT_W:0]   cnt_incl;

  // cnt_q holds the refusals seen before this cycle; counting the present
  // cycle too tells us whether this one would be the STARVE_MAX-th refusal,
  // in which case the arbiter hands over instead of refusing again.
  assign cnt_incl = {1'b0, cnt_q} + 1'b1;
  assign limit    = (cnt_incl >= CNT_MAX_X);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (dma_wait && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Purpose  : Shares the single-port data memory between the CPU load/store  |
// |            path and a DMA/debug word port. CPU has zero added latency;     |
// |            a DMA grant costs the CPU at most one stall cycle.              |
// | Ports    : clk, rst                  clock / async active-high reset       |
// |            cpu_req/we/addr/wdata in  CPU access request                    |
// |            cpu_rdata            out  mem_rdata pass-through                |
// |            cpu_stall            out  CPU must hold this cycle              |
// |            dma_req/we/addr/wdata in  DMA beat, held until dma_ack          |
// |            dma_rdata            out  registered DMA read data              |
// |            dma_ack              out  DMA beat performed this cycle         |
// |            mem_we/addr/wdata    out  data-memory write port                |
// |            mem_rdata            in   data-memory combinational read data   |
// | Config   : `define DMEM_ARB_STARVE_GUARD_EN to force a DMA grant after     |
// |            STARVE_MAX refused cycles; otherwise strict CPU priority.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  owner_e      owner_q;
  owner_e      owner_d;
  logic [31:0] dma_rdata_q;
  logic [31:0] dma_rdata_d;
  logic        starve_limit;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic starve_wait;
  logic starve_clear;

  // A refused cycle is one where the DMA asks, the CPU owns the bus and keeps it.
  assign starve_wait  = (owner_q == OWN_CPU) && dma_req && (owner_d == OWN_CPU);
  assign starve_clear = !dma_req || (owner_d == OWN_DMA);

  dmem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .dma_wait (starve_wait),
    .clear    (starve_clear),
    .limit    (starve_limit)
  );
`else
  // Strict CPU priority: the DMA only gets in on cycles the CPU leaves idle.
  // STARVE_MAX has no effect in this build.
  logic [31:0] unused_starve_max;
  assign unused_starve_max = STARVE_MAX;
  assign starve_limit      = 1'b0;
`endif

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = dma_rdata_q;

  always_comb begin
    owner_d     = OWN_CPU;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;
    mem_we      = cpu_req & cpu_we;
    cpu_stall   = 1'b0;
    dma_ack     = 1'b0;
    dma_rdata_d = dma_rdata_q;

    case (owner_q)
      OWN_CPU: begin
        if (dma_req && (!cpu_req || starve_limit)) begin
          owner_d = OWN_DMA;
        end
      end
      OWN_DMA: begin
        // The CPU bus is ignored entirely here, so a CPU store cannot leak.
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_req & dma_we;
        cpu_stall = cpu_req;
        dma_ack   = dma_req;
        // Stay only while the CPU is quiet; any CPU request wins the next cycle.
        if (dma_req && !cpu_req) begin
          owner_d = OWN_DMA;
        end
      end
      default: begin
        owner_d = OWN_CPU;
      end
    endcase

    // Reset takes the write strobe and handshakes down without waiting for
    // the state register, so an in-flight beat never reaches memory.
    if (rst) begin
      mem_we    = 1'b0;
      cpu_stall = 1'b0;
      dma_ack   = 1'b0;
    end

    if (dma_ack && !dma_we) begin
      dma_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_CPU;
      dma_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive denied DMA cycles before forced DMA grant (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cpu_req  input  1  CPU load/store request this cycle.
REQ-005 SHALL have port cpu_we  input  1  CPU store when high.
REQ-006 SHALL have port cpu_addr  input  32  CPU byte address (alu_out).
REQ-007 SHALL have port cpu_wdata  input  32  CPU store data.
REQ-008 SHALL have port cpu_rdata  output  32  CPU load data, combinational pass-through of mem_rdata.
REQ-009 SHALL have port cpu_stall  output  1  CPU must hold PC and suppress register writes.
REQ-010 SHALL have port dma_req  input  1  DMA/debug word request, held until dma_ack.
REQ-011 SHALL have port dma_we  input  1  DMA write when high.
REQ-012 SHALL have port dma_addr  input  32  DMA byte address.
REQ-013 SHALL have port dma_wdata  input  32  DMA write data.
REQ-014 SHALL have port dma_rdata  output  32  registered DMA read data.
REQ-015 SHALL have port dma_ack  output  1  one-cycle pulse; DMA beat performed this cycle.
REQ-016 SHALL have port mem_we  output  1  data memory write enable.
REQ-017 SHALL have port mem_addr  output  32  data memory address.
REQ-018 SHALL have port mem_wdata  output  32  data memory write data.
REQ-019 SHALL have port mem_rdata  input  32  data memory combinational read data.

Function
REQ-020 SHALL hold owner state {OWN_CPU, OWN_DMA}; OWN_CPU is the parking state.
REQ-021 SHALL drive mem_addr/mem_wdata from the owner's bus; mem_we = owner_req AND owner_we AND NOT rst.
REQ-022 In OWN_CPU: cpu_stall=0, dma_ack=0; CPU access completes in the same cycle (zero added latency).
REQ-023 In OWN_DMA: cpu_stall=cpu_req; dma_ack=dma_req; cpu_we never reaches mem_we.
REQ-024 OWN_CPU->OWN_DMA at the edge when dma_req=1 AND (cpu_req=0 OR starvation limit reached); otherwise stay in OWN_CPU.
REQ-025 OWN_DMA->OWN_DMA when dma_req=1 AND cpu_req=0 (back-to-back beats); otherwise ->OWN_CPU, so the CPU stalls at most 1 cycle per DMA grant.
REQ-026 On a dma_ack cycle with dma_we=0, dma_rdata SHALL capture mem_rdata at the closing edge and hold until the next DMA read beat.
REQ-027 dma_req dropped while in OWN_DMA: no ack, mem_we=0, next state OWN_CPU.
REQ-028 cpu_req=0 and dma_req=0: state OWN_CPU, mem_we=0, no ack, no stall.

Reset
REQ-029 rst=1 SHALL immediately force state OWN_CPU, starvation count 0, dma_rdata 0, dma_ack 0, cpu_stall 0, mem_we 0.
REQ-030 Reset mid-DMA-beat SHALL abort the beat with no write; after release, DMA must re-request.

Configuration
REQ-031 Macro DMEM_ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-032 Defined: counter increments each OWN_CPU cycle with dma_req=1 and no grant, saturates at STARVE_MAX, clears on entering OWN_DMA or dma_req=0; at STARVE_MAX, next state is OWN_DMA regardless of cpu_req.
REQ-033 Undefined: no counter; the limit condition is constant false; strict CPU priority, and DMA may starve.

Structure
REQ-034 Shared package dmem_arb_pkg SHALL hold the owner-state encoding (OWN_CPU=0, OWN_DMA=1) and the STARVE_MAX default.
REQ-035 Starvation counter SHALL be sub-module dmem_arb_starve_cnt, instantiated only under DMEM_ARB_STARVE_GUARD_EN.
REQ-036 dmem_arbiter SHALL sit between mips and data_mem in top; mips stall gating is outside this block.

Verification
REQ-037 CPU-only: cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF -> mem_we=1 the same cycle, cpu_stall never 1, mem[0x10]=0xDEADBEEF.
REQ-038 DMA on idle CPU: dma_req=1, dma_we=0, addr 0x20 holding 0x12345678, cpu_req=0 -> dma_ack 1 cycle later, dma_rdata=0x12345678 after that edge.
REQ-039 Collision: DMA active, cpu_req rises -> cpu_stall=1 for exactly 1 cycle, then CPU is served and the DMA ack count does not increase.
REQ-040 Starvation (macro defined, STARVE_MAX=4): cpu_req and dma_req held high -> DMA granted on the 5th cycle, one stall cycle; with the macro undefined, dma_ack is never seen.
REQ-041 Async reset while in OWN_DMA with dma_we=1 -> mem_we falls without waiting for a clock edge, memory is unchanged, and the state is OWN_CPU after release.
REQ-042 Back-to-back DMA: 3 beats with cpu_req=0 -> 3 consecutive dma_ack pulses with no OWN_CPU cycles between them.
